// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes, FSM encoding and default widths for the calc engine
package calc_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OPND_W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_SQR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_FIN     = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

endpackage

// File: rtl/calc_iter_unit.sv
// rtl/calc_iter_unit.sv - shared shift-add multiplier / restoring divider, DATA_W steps
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  iter_mode_t            mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic [DATA_W-1:0]     quotient,
  output logic [DATA_W-1:0]     remainder,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] hi, lo, b_q;
  iter_mode_t        mode_q;
  logic              running;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] src_hi, src_lo, src_b;
  iter_mode_t        src_mode;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;
  logic [DATA_W-1:0] step_hi, step_lo;

  // The first step is applied to the operands as they are loaded, so the
  // result is ready after exactly DATA_W clock edges.
  always_comb begin
    src_hi    = start ? '0 : hi;
    src_lo    = start ? a : lo;
    src_b     = start ? b : b_q;
    src_mode  = start ? mode : mode_q;
    mul_sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
    div_shift = {src_hi, src_lo[DATA_W-1]};
    div_diff  = div_shift - {1'b0, src_b};
    if (src_mode == MODE_MUL) begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], src_lo[DATA_W-1:1]};
    end else begin
      step_hi = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
      step_lo = {src_lo[DATA_W-2:0], ~div_diff[DATA_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      b_q     <= '0;
      mode_q  <= MODE_MUL;
      running <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi      <= step_hi;
        lo      <= step_lo;
        b_q     <= b;
        mode_q  <= mode;
        cnt     <= CNT_W'(1);
        running <= 1'b1;
      end else if (running) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(DATA_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product   = {hi, lo};
  assign quotient  = lo;
  assign remainder = hi;

endmodule

// File: rtl/calc_engine.sv
// rtl/calc_engine.sv - button-triggered accumulator calculator with iterative mul/div
module calc_engine
  import calc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPND_W = DEF_OPND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic [2:0]        func,
  input  logic [OPND_W-1:0] num1,
  input  logic [OPND_W-1:0] num2,
  output logic [DATA_W-1:0] cal_result,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  state_t              state, state_n;
  logic                btn_q, trig, accept, is_mod;
  logic [DATA_W-1:0]   a_val, b_val, res_n, iter_b;
  logic [DATA_W:0]     add_full, sub_full;
  logic                done_n, err_n, ovf_n;
  logic                iter_start, iter_done;
  iter_mode_t          iter_mode;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quotient, remainder;

  assign trig     = button & ~btn_q;
  assign accept   = trig && (state == ST_IDLE);
  assign a_val    = cal_result + DATA_W'(num1);
  assign b_val    = DATA_W'(num2);
  assign add_full = {1'b0, a_val} + {1'b0, b_val};
  assign sub_full = {1'b0, a_val} - {1'b0, b_val};
  assign busy     = (state == ST_MUL_RUN) || (state == ST_DIV_RUN);

  always_comb begin
    state_n    = state;
    res_n      = cal_result;
    done_n     = 1'b0;
    err_n      = err;
    ovf_n      = ovf;
    iter_start = 1'b0;
    iter_mode  = MODE_MUL;
    iter_b     = b_val;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          err_n = 1'b0;
          case (func)
            OP_ADD: begin
              res_n   = add_full[DATA_W-1:0];
              ovf_n   = add_full[DATA_W];
              done_n  = 1'b1;
              state_n = ST_FIN;
            end
            OP_SUB: begin
              res_n   = sub_full[DATA_W-1:0];
              ovf_n   = sub_full[DATA_W];
              done_n  = 1'b1;
              state_n = ST_FIN;
            end
            OP_MUL, OP_SQR: begin
              iter_start = 1'b1;
              iter_b     = (func == OP_SQR) ? a_val : b_val;
              state_n    = ST_MUL_RUN;
            end
            OP_DIV, OP_MOD: begin
              if (b_val == '0) begin
                err_n   = 1'b1;
                ovf_n   = 1'b0;
                done_n  = 1'b1;
                state_n = ST_FIN;
              end else begin
                iter_start = 1'b1;
                iter_mode  = MODE_DIV;
                state_n    = ST_DIV_RUN;
              end
            end
            default: begin
              res_n   = '0;
              ovf_n   = 1'b0;
              done_n  = 1'b1;
              state_n = ST_FIN;
            end
          endcase
        end
      end
      ST_MUL_RUN: begin
        if (iter_done) begin
          res_n   = product[DATA_W-1:0];
          ovf_n   = |product[2*DATA_W-1:DATA_W];
          done_n  = 1'b1;
          state_n = ST_FIN;
        end
      end
      ST_DIV_RUN: begin
        if (iter_done) begin
          res_n   = is_mod ? remainder : quotient;
          ovf_n   = 1'b0;
          done_n  = 1'b1;
          state_n = ST_FIN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      btn_q      <= 1'b0;
      cal_result <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      ovf        <= 1'b0;
      is_mod     <= 1'b0;
    end else begin
      state      <= state_n;
      btn_q      <= button;
      cal_result <= res_n;
      done       <= done_n;
      err        <= err_n;
      ovf        <= ovf_n;
      if (accept) is_mod <= (func == OP_MOD);
    end
  end

  calc_iter_unit #(.DATA_W(DATA_W)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (iter_start),
    .mode      (iter_mode),
    .a         (a_val),
    .b         (iter_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (iter_done)
  );

endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 Parameter DATA_W, default 32: accumulator/result width, legal 8..64.
REQ-002 Parameter OPND_W, default 8: operand width, legal 4..DATA_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 button  input  1  level request; an operation is triggered only on its rising edge.
REQ-006 func  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 SQR, 6/7 CLR.
REQ-007 num1  input  OPND_W  pre-add operand, zero-extended.
REQ-008 num2  input  OPND_W  second operand, zero-extended.
REQ-009 cal_result  output  DATA_W  accumulator value.
REQ-010 busy  output  1  high while a multi-cycle operation runs.
REQ-011 done  output  1  one-cycle pulse when cal_result is updated or an error is flagged.
REQ-012 err  output  1  sticky divide-by-zero flag; cleared by the next accepted trigger.
REQ-013 ovf  output  1  high when the last result was truncated; updated with every done pulse.

Function
REQ-014 A = cal_result + num1; B = num2. All arithmetic is unsigned, modulo 2^DATA_W.
REQ-015 ADD -> A+B; SUB -> A-B (wraps, ovf=1 on borrow); MUL -> A*B; SQR -> A*A; DIV -> A/B; MOD -> A%B; CLR -> 0.
REQ-016 func, num1 and num2 are sampled only in the cycle of the button rising edge; later changes do not affect the running operation.
REQ-017 Edge detection uses one registered copy of button; a held level never retriggers.
REQ-018 States: IDLE, MUL_RUN, DIV_RUN, FIN. ADD/SUB/CLR go IDLE->FIN; MUL/SQR go IDLE->MUL_RUN; DIV/MOD go IDLE->DIV_RUN. FIN->IDLE always.
REQ-019 ADD/SUB/CLR: cal_result updates and done pulses 1 cycle after the trigger edge; busy stays 0.
REQ-020 MUL/SQR use an iterative shift-add of exactly DATA_W steps; DIV/MOD use a restoring divider of exactly DATA_W steps.
REQ-021 Multi-cycle latency: busy is high from the cycle after the trigger for DATA_W cycles; cal_result updates and done pulses in the cycle after that (DATA_W+1 cycles after the trigger).
REQ-022 MUL/SQR: ovf=1 if any bit of the 2*DATA_W product above bit DATA_W-1 is set; the low DATA_W bits are stored.
REQ-023 DIV/MOD with B=0: no iterations run; cal_result is unchanged; err=1 and done pulses 1 cycle after the trigger.
REQ-024 A trigger edge while busy=1 or in FIN is ignored entirely and is not queued.
REQ-025 cal_result changes only in the done cycle or on reset; it is stable at all other times.

Reset
REQ-026 While rst=1, the block is in IDLE with cal_result=0, busy=0, done=0, err=0, ovf=0, and the registered button copy=0.
REQ-027 rst asserted mid-operation aborts the operation at the next edge; no done pulse is produced for the aborted operation.
REQ-028 A button held high through reset release triggers one operation in the first cycle after release (registered copy is 0).

Structure
REQ-029 A shared package calc_pkg holds the opcode constants, the state encoding and the default widths.
REQ-030 The shared iterative datapath is one sub-module, calc_iter_unit. It takes start, mode (mul/div), A and B, and returns product/quotient/remainder and a done strobe.
REQ-031 The top level holds edge detection, the FSM, the accumulator and the flags; seven-segment display logic stays outside this block.

Verification
REQ-032 DATA_W=32, sequence from reset: ADD 6,4 -> 0x0A; MUL 0,0x0C -> 0x78; SQR -> 0x3840; SUB 0,0xC8 -> 0x3778; DIV 0,8 -> 0x6EF; SQR -> 0x301321; MOD 0,8 -> 0x1.
REQ-033 Latency check: MUL done exactly 33 cycles after the trigger edge, busy high for 32 cycles; ADD done 1 cycle after the trigger, busy never high.
REQ-034 DIV with num2=0 while cal_result=0x55 -> err=1, cal_result stays 0x55, done after 1 cycle; next ADD 0,1 -> err=0, cal_result 0x56.
REQ-035 DATA_W=8: cal_result 0x10, SQR -> cal_result 0x00, ovf=1; SUB 0,1 from 0 -> 0xFF, ovf=1.
REQ-036 Second button edge 5 cycles into a MUL -> ignored; only one done pulse; func change mid-run does not alter the result.
REQ-037 rst pulse at cycle 10 of a DIV -> no done pulse, cal_result=0, IDLE; a new ADD 2,3 then gives 0x05.
